cpu_control_fsm: RTL

Multicycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's `op_sel` and operand selects, and consumes the ALU's `z_flag` to resolve branches. It sits directly upstream of `cpu_alu` and steers the shared-memory datapath: PC, IR, register file and ALU-out register.

---
 rtl/pkg_cpu_typedefs.sv | 90 +++++++++
 rtl/cpu_alu_decoder.sv | 59 +++++
 rtl/cpu_control_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pkg_cpu_typedefs.sv
// Shared type definitions for the RV32I multicycle core: ALU operations,
// control FSM states, opcode constants and datapath select encodings.
package pkg_cpu_typedefs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JALR      = 4'd10,
    ST_JAL       = 4'd11,
    ST_LUI       = 4'd12,
    ST_AUIPC     = 4'd13
  } cpu_state_t;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operand A sources
  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;
  localparam logic [1:0] SRC_A_ZERO   = 2'd3;

  // ALU operand B sources
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Register-file / PC write-back sources
  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // Memory address sources
  localparam logic ADDR_PC      = 1'b0;
  localparam logic ADDR_ALU_OUT = 1'b1;

  // Arithmetic/logic op from funct3; sub_en/sra_en pick the alternate
  // encodings that share funct3 000 and 101.
  function automatic alu_op_t funct3_to_op(logic [2:0] funct3, logic sub_en, logic sra_en);
    alu_op_t op;
    case (funct3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu_decoder.sv
// Combinational instruction classifier: ALU operation for R, OP-IMM and
// branch instructions, plus detection of undecodable encodings.
module cpu_alu_decoder
  import pkg_cpu_typedefs::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op,
  output logic       illegal
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);

  // Decode the operation and legality of the current opcode
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op  = funct3_to_op(funct3, funct7[5], funct7[5]);
        illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        alu_op = funct3_to_op(funct3, 1'b0, funct7[5]);
        if (funct3 == 3'b001) begin
          illegal = !f7_zero;
        end else if (funct3 == 3'b101) begin
          illegal = !(f7_zero || f7_alt);
        end
      end
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        illegal = (funct3 > 3'b010);
      end
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
        illegal = 1'b0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch, decode, execute, memory
// and write-back, steering the ALU selects and datapath write enables.
module cpu_control_fsm
  import pkg_cpu_typedefs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  z_flag,
  input  logic                  mem_ready,
  output logic [3:0]            alu_op_sel,
  output logic [1:0]            alu_src_a_sel,
  output logic [1:0]            alu_src_b_sel,
  output logic [2:0]            imm_sel,
  output logic [1:0]            result_sel,
  output logic                  addr_sel,
  output logic                  pc_we,
  output logic                  ir_we,
  output logic                  rf_we,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  illegal_instr,
  output logic [3:0]            fsm_state
);

  cpu_state_t state_reg;
  cpu_state_t state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_t    dec_op;
  logic       dec_illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices and immediates are consumed by the datapath only
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  cpu_alu_decoder u_alu_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  // State register with synchronous active-low reset back to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode; everything is forced low during reset
  always_comb begin
    state_next    = state_reg;
    alu_op_sel    = ALU_ADD;
    alu_src_a_sel = SRC_A_PC;
    alu_src_b_sel = SRC_B_RS2;
    imm_sel       = IMM_I;
    result_sel    = RES_ALU_OUT;
    addr_sel      = ADDR_PC;
    pc_we         = 1'b0;
    ir_we         = 1'b0;
    rf_we         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    illegal_instr = 1'b0;
    fsm_state     = ST_FETCH;
    if (rst_n) begin
      fsm_state = state_reg;
      case (state_reg)
        ST_FETCH: begin
          addr_sel      = ADDR_PC;
          mem_req       = 1'b1;
          alu_src_a_sel = SRC_A_PC;
          alu_src_b_sel = SRC_B_FOUR;
          result_sel    = RES_ALU;
          ir_we         = mem_ready;
          pc_we         = mem_ready;
          if (mem_ready) state_next = ST_DECODE;
        end
        ST_DECODE: begin
          // Branch/jump target precomputed into the ALU-out register
          alu_src_a_sel = SRC_A_OLD_PC;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = (opcode == OPC_JAL) ? IMM_J : IMM_B;
          if (dec_illegal) begin
            illegal_instr = 1'b1;
            state_next    = ST_FETCH;
          end else begin
            case (opcode)
              OPC_LOAD, OPC_STORE: state_next = ST_MEM_ADDR;
              OPC_OP:              state_next = ST_EXEC_R;
              OPC_OP_IMM:          state_next = ST_EXEC_I;
              OPC_BRANCH:          state_next = ST_BRANCH;
              OPC_JAL:             state_next = ST_JAL;
              OPC_JALR:            state_next = ST_JALR;
              OPC_LUI:             state_next = ST_LUI;
              OPC_AUIPC:           state_next = ST_AUIPC;
              default:             state_next = ST_FETCH;
            endcase
          end
        end
        ST_MEM_ADDR: begin
          alu_src_a_sel = SRC_A_RS1;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = (opcode == OPC_LOAD) ? IMM_I : IMM_S;
          state_next    = (opcode == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
        end
        ST_MEM_READ: begin
          addr_sel = ADDR_ALU_OUT;
          mem_req  = 1'b1;
          if (mem_ready) state_next = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          result_sel = RES_MEM;
          rf_we      = 1'b1;
          state_next = ST_FETCH;
        end
        ST_MEM_WRITE: begin
          addr_sel = ADDR_ALU_OUT;
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          if (mem_ready) state_next = ST_FETCH;
        end
        ST_EXEC_R: begin
          alu_src_a_sel = SRC_A_RS1;
          alu_src_b_sel = SRC_B_RS2;
          alu_op_sel    = dec_op;
          state_next    = ST_ALU_WB;
        end
        ST_EXEC_I: begin
          alu_src_a_sel = SRC_A_RS1;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = IMM_I;
          alu_op_sel    = dec_op;
          state_next    = ST_ALU_WB;
        end
        ST_ALU_WB: begin
          result_sel = RES_ALU_OUT;
          rf_we      = 1'b1;
          state_next = ST_FETCH;
        end
        ST_BRANCH: begin
          // funct3[0] inverts the sense; the SLT family inverts it again
          alu_src_a_sel = SRC_A_RS1;
          alu_src_b_sel = SRC_B_RS2;
          result_sel    = RES_ALU_OUT;
          alu_op_sel    = dec_op;
          pc_we         = z_flag ^ funct3[0] ^ funct3[2];
          state_next    = ST_FETCH;
        end
        ST_JALR: begin
          alu_src_a_sel = SRC_A_RS1;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = IMM_I;
          state_next    = ST_JAL;
        end
        ST_JAL: begin
          // PC takes the target while the ALU forms the link address
          pc_we         = 1'b1;
          result_sel    = RES_ALU_OUT;
          alu_src_a_sel = SRC_A_OLD_PC;
          alu_src_b_sel = SRC_B_FOUR;
          state_next    = ST_ALU_WB;
        end
        ST_LUI: begin
          alu_src_a_sel = SRC_A_ZERO;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = IMM_U;
          state_next    = ST_ALU_WB;
        end
        ST_AUIPC: begin
          alu_src_a_sel = SRC_A_OLD_PC;
          alu_src_b_sel = SRC_B_IMM;
          imm_sel       = IMM_U;
          state_next    = ST_ALU_WB;
        end
        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

endmodule
